// File: rtl/axis_frame_rx.sv
// axis_frame_rx: AXI-Stream receiver that forwards every beat through a
// two-entry skid buffer and, in parallel, tracks frame boundaries to report
// per-frame byte length, tkeep-rule violations, oversize and a frame count.
// Frame statistics are taken at input acceptance, so they do not depend on
// backpressure from the master side.
module axis_frame_rx #(
    parameter int TDATA_WIDTH     = 64,
    parameter int TID_WIDTH       = 1,
    parameter int TDEST_WIDTH     = 1,
    parameter int TUSER_WIDTH     = 1,
    parameter int MAX_FRAME_BYTES = 1522
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic                     s_tlast,
    input  logic [TDATA_WIDTH-1:0]   s_tdata,
    input  logic [TDATA_WIDTH/8-1:0] s_tstrb,
    input  logic [TDATA_WIDTH/8-1:0] s_tkeep,
    input  logic [TID_WIDTH-1:0]     s_tid,
    input  logic [TDEST_WIDTH-1:0]   s_tdest,
    input  logic [TUSER_WIDTH-1:0]   s_tuser,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic [TDATA_WIDTH-1:0]   m_tdata,
    output logic [TDATA_WIDTH/8-1:0] m_tstrb,
    output logic [TDATA_WIDTH/8-1:0] m_tkeep,
    output logic [TID_WIDTH-1:0]     m_tid,
    output logic [TDEST_WIDTH-1:0]   m_tdest,
    output logic [TUSER_WIDTH-1:0]   m_tuser,
    output logic                     frm_done,
    output logic [15:0]              frm_len,
    output logic                     frm_err_keep,
    output logic                     frm_err_oversize,
    output logic [31:0]              frm_count
);

    localparam int KB       = TDATA_WIDTH / 8;
    // Packed beat layout, LSB first: user, dest, id, last, keep, strb, data
    localparam int OFF_DEST = TUSER_WIDTH;
    localparam int OFF_ID   = OFF_DEST + TDEST_WIDTH;
    localparam int OFF_LAST = OFF_ID + TID_WIDTH;
    localparam int OFF_KEEP = OFF_LAST + 1;
    localparam int OFF_STRB = OFF_KEEP + KB;
    localparam int OFF_DATA = OFF_STRB + KB;
    localparam int BW       = OFF_DATA + TDATA_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } state_e;

    // Number of valid bytes in a beat (17 bits so the length sum can detect overflow)
    function automatic logic [16:0] popcount(input logic [KB-1:0] v);
        logic [16:0] c;
        c = 17'd0;
        for (int i = 0; i < KB; i++) begin
            c = c + {16'd0, v[i]};
        end
        return c;
    endfunction

    // Non-last beats must be full; the last beat must be a nonzero run of ones from bit 0
    function automatic logic keep_violation(input logic [KB-1:0] k, input logic last);
        logic bad;
        if (!last) begin
            bad = (k != {KB{1'b1}});
        end else begin
            bad = (k == {KB{1'b0}}) || ((k & (k + KB'(1))) != {KB{1'b0}});
        end
        return bad;
    endfunction

    logic [BW-1:0] beat_in_s;
    logic          accept_s;
    logic          xfer_s;

    logic [BW-1:0] out_beat_q, out_beat_d;
    logic          out_valid_q, out_valid_d;
    logic [BW-1:0] skid_beat_q, skid_beat_d;
    logic          skid_valid_q, skid_valid_d;
    logic          s_tready_q, s_tready_d;

    state_e        state_q, state_d;

    logic [16:0]   bytes_s;
    logic [16:0]   sum_s;
    logic [15:0]   len_sum_s;
    logic          viol_s;
    logic          over_s;

    logic [15:0]   acc_len_q, acc_len_d;
    logic          acc_err_keep_q, acc_err_keep_d;
    logic          acc_over_q, acc_over_d;
    logic          frm_done_q, frm_done_d;
    logic [15:0]   frm_len_q, frm_len_d;
    logic          frm_err_keep_q, frm_err_keep_d;
    logic          frm_err_over_q, frm_err_over_d;
    logic [31:0]   frm_count_q, frm_count_d;

    assign beat_in_s = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
    assign accept_s  = s_tvalid & s_tready_q;
    assign xfer_s    = out_valid_q & m_tready;

    // Skid buffer next state: skid refills output first, then new beats fill output or skid
    always_comb begin
        out_beat_d   = out_beat_q;
        out_valid_d  = out_valid_q;
        skid_beat_d  = skid_beat_q;
        skid_valid_d = skid_valid_q;
        if (xfer_s && skid_valid_q) begin
            // s_tready is low while the skid is full, so no new beat can arrive here
            out_beat_d   = skid_beat_q;
            skid_valid_d = 1'b0;
        end else if (accept_s && (!out_valid_q || m_tready)) begin
            out_beat_d  = beat_in_s;
            out_valid_d = 1'b1;
        end else if (accept_s) begin
            skid_beat_d  = beat_in_s;
            skid_valid_d = 1'b1;
        end else if (xfer_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        s_tready_d = ~skid_valid_d;
    end

    // Skid buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_beat_q   <= {BW{1'b0}};
            out_valid_q  <= 1'b0;
            skid_beat_q  <= {BW{1'b0}};
            skid_valid_q <= 1'b0;
            s_tready_q   <= 1'b0;
        end else begin
            out_beat_q   <= out_beat_d;
            out_valid_q  <= out_valid_d;
            skid_beat_q  <= skid_beat_d;
            skid_valid_q <= skid_valid_d;
            s_tready_q   <= s_tready_d;
        end
    end

    // Frame FSM next state, advanced only on accepted input beats
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && !s_tlast) begin
                    state_d = ST_IN_FRAME;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IN_FRAME: begin
                if (accept_s && s_tlast) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_IN_FRAME;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-beat statistics: saturating length, keep rule and oversize
    always_comb begin
        bytes_s   = popcount(s_tkeep);
        sum_s     = {1'b0, acc_len_q} + bytes_s;
        len_sum_s = sum_s[16] ? 16'hFFFF : sum_s[15:0];
        viol_s    = keep_violation(s_tkeep, s_tlast);
        over_s    = (32'(len_sum_s) > 32'(MAX_FRAME_BYTES));
    end

    // Accumulate during a frame; publish and clear on its last accepted beat
    always_comb begin
        acc_len_d      = acc_len_q;
        acc_err_keep_d = acc_err_keep_q;
        acc_over_d     = acc_over_q;
        frm_done_d     = 1'b0;
        frm_len_d      = frm_len_q;
        frm_err_keep_d = frm_err_keep_q;
        frm_err_over_d = frm_err_over_q;
        frm_count_d    = frm_count_q;
        if (accept_s) begin
            if (s_tlast) begin
                frm_done_d     = 1'b1;
                frm_len_d      = len_sum_s;
                frm_err_keep_d = acc_err_keep_q | viol_s;
                frm_err_over_d = acc_over_q | over_s;
                frm_count_d    = frm_count_q + 32'd1;
                acc_len_d      = 16'd0;
                acc_err_keep_d = 1'b0;
                acc_over_d     = 1'b0;
            end else begin
                acc_len_d      = len_sum_s;
                acc_err_keep_d = acc_err_keep_q | viol_s;
                acc_over_d     = acc_over_q | over_s;
            end
        end else begin
            frm_done_d = 1'b0;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_len_q      <= 16'd0;
            acc_err_keep_q <= 1'b0;
            acc_over_q     <= 1'b0;
            frm_done_q     <= 1'b0;
            frm_len_q      <= 16'd0;
            frm_err_keep_q <= 1'b0;
            frm_err_over_q <= 1'b0;
            frm_count_q    <= 32'd0;
        end else begin
            acc_len_q      <= acc_len_d;
            acc_err_keep_q <= acc_err_keep_d;
            acc_over_q     <= acc_over_d;
            frm_done_q     <= frm_done_d;
            frm_len_q      <= frm_len_d;
            frm_err_keep_q <= frm_err_keep_d;
            frm_err_over_q <= frm_err_over_d;
            frm_count_q    <= frm_count_d;
        end
    end

    assign s_tready         = s_tready_q;
    assign m_tvalid         = out_valid_q;
    assign m_tdata          = out_beat_q[OFF_DATA +: TDATA_WIDTH];
    assign m_tstrb          = out_beat_q[OFF_STRB +: KB];
    assign m_tkeep          = out_beat_q[OFF_KEEP +: KB];
    assign m_tlast          = out_beat_q[OFF_LAST];
    assign m_tid            = out_beat_q[OFF_ID +: TID_WIDTH];
    assign m_tdest          = out_beat_q[OFF_DEST +: TDEST_WIDTH];
    assign m_tuser          = out_beat_q[0 +: TUSER_WIDTH];
    assign frm_done         = frm_done_q;
    assign frm_len          = frm_len_q;
    assign frm_err_keep     = frm_err_keep_q;
    assign frm_err_oversize = frm_err_over_q;
    assign frm_count        = frm_count_q;

endmodule

// File: tb/tb_axis_frame_rx.sv
// tb_axis_frame_rx: randomized and directed stimulus for axis_frame_rx,
// checked every cycle against a queue-based behavioural model (beats in
// flight as a FIFO, frame statistics computed from the whole frame's keeps).
module tb_axis_frame_rx;

    localparam int DW   = 64;
    localparam int KB   = 8;
    localparam int MAXB = 1522;

    // beat layout: [83:20] data, [19:12] strb, [11:4] keep, [3] last, [2] id, [1] dest, [0] user
    typedef logic [83:0] beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic [KB-1:0] s_tstrb = '0;
    logic [KB-1:0] s_tkeep = '0;
    logic [0:0]    s_tid = '0;
    logic [0:0]    s_tdest = '0;
    logic [0:0]    s_tuser = '0;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic [DW-1:0] m_tdata;
    logic [KB-1:0] m_tstrb;
    logic [KB-1:0] m_tkeep;
    logic [0:0]    m_tid;
    logic [0:0]    m_tdest;
    logic [0:0]    m_tuser;
    logic          frm_done;
    logic [15:0]   frm_len;
    logic          frm_err_keep;
    logic          frm_err_oversize;
    logic [31:0]   frm_count;

    axis_frame_rx dut (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tkeep(s_tkeep),
        .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep),
        .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
        .frm_done(frm_done), .frm_len(frm_len), .frm_err_keep(frm_err_keep),
        .frm_err_oversize(frm_err_oversize), .frm_count(frm_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    beat_t       in_q[$];     // beats waiting to be offered
    beat_t       exp_q[$];    // beats accepted but not yet delivered
    logic [7:0]  cur_keeps[$];
    logic        rdy_armed = 1'b0;
    logic        exp_done = 1'b0;
    logic [15:0] exp_len = 16'd0;
    logic        exp_ek = 1'b0;
    logic        exp_eo = 1'b0;
    logic [31:0] exp_cnt = 32'd0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bit is_contig(input logic [7:0] k);
        bit ok;
        ok = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            if (int'(k) == (1 << n) - 1) ok = 1'b1;
        end
        return ok;
    endfunction

    // Whole-frame statistics from the list of keeps seen in the frame
    task automatic close_frame();
        int len;
        bit ek;
        len = 0;
        ek  = 1'b0;
        for (int i = 0; i < cur_keeps.size(); i++) begin
            len += $countones(cur_keeps[i]);
            if (i < cur_keeps.size() - 1) ek |= (cur_keeps[i] != 8'hFF);
            else                          ek |= !is_contig(cur_keeps[i]);
        end
        if (len > 65535) len = 65535;
        exp_len = 16'(len);
        exp_ek  = ek;
        exp_eo  = (len > MAXB);
        exp_cnt = exp_cnt + 32'd1;
        cur_keeps.delete();
    endtask

    task automatic push_frame(input int n, input int bad_idx, input logic [7:0] bad_keep,
                              input logic [7:0] last_keep);
        beat_t b;
        logic [7:0] k;
        for (int i = 0; i < n; i++) begin
            k = (i == n - 1) ? last_keep : ((i == bad_idx) ? bad_keep : 8'hFF);
            b = {$urandom, $urandom, 8'($urandom), k, (i == n - 1), 3'($urandom)};
            in_q.push_back(b);
        end
    endtask

    task automatic compare();
        beat_t mb;
        mb = {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
        chk("s_tready", 96'(s_tready), 96'(rdy_armed && exp_q.size() < 2));
        chk("m_tvalid", 96'(m_tvalid), 96'(exp_q.size() > 0));
        if (exp_q.size() > 0) chk("m_beat", 96'(mb), 96'(exp_q[0]));
        if (!rst_n) chk("m_beat_rst", 96'(mb), 96'd0);
        chk("frm_done", 96'(frm_done), 96'(exp_done));
        chk("frm_len", 96'(frm_len), 96'(exp_len));
        chk("frm_err_keep", 96'(frm_err_keep), 96'(exp_ek));
        chk("frm_err_oversize", 96'(frm_err_oversize), 96'(exp_eo));
        chk("frm_count", 96'(frm_count), 96'(exp_cnt));
    endtask

    // One clock: check at negedge, drive, then apply the edge to the model
    task automatic step(input int vprob, input int rprob);
        bit acc;
        bit xf;
        beat_t b;
        @(negedge clk);
        compare();
        if (in_q.size() > 0 && rst_n && int'($urandom_range(99)) < vprob) begin
            b = in_q[0];
            s_tvalid = 1'b1;
        end else begin
            b = {$urandom, $urandom, $urandom};
            s_tvalid = 1'b0;
        end
        {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser} = b;
        m_tready = (int'($urandom_range(99)) < rprob);
        acc = s_tvalid && rdy_armed && (exp_q.size() < 2);
        xf  = m_tready && (exp_q.size() > 0);
        @(posedge clk);
        if (rst_n) begin
            exp_done = 1'b0;
            if (xf) void'(exp_q.pop_front());
            if (acc) begin
                b = in_q.pop_front();
                exp_q.push_back(b);
                cur_keeps.push_back(b[11:4]);
                if (b[3]) begin
                    close_frame();
                    exp_done = 1'b1;
                end
            end
        end
    endtask

    task automatic drain(input int vprob, input int rprob);
        int n;
        n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < 5000) begin
            step(vprob, rprob);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=<5000", n);
        end
        step(0, 100);
        step(0, 100);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        s_tvalid = 1'b0;
        chk("s_tready_at_release", 96'(s_tready), 96'd0);
        @(posedge clk);
        rdy_armed = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        in_q.delete();
        exp_q.delete();
        cur_keeps.delete();
        rdy_armed = 1'b0;
        exp_done = 1'b0;
        exp_len = 16'd0;
        exp_ek = 1'b0;
        exp_eo = 1'b0;
        exp_cnt = 32'd0;
        step(0, 50);
        step(0, 50);
        release_reset();
    endtask

    initial begin
        int n;
        int bi;
        logic [7:0] lk;
        // reset state
        step(0, 50);
        step(0, 50);
        release_reset();

        // 8 full beats, ready held high
        push_frame(8, -1, 8'h00, 8'hFF);
        drain(100, 100);
        chk("lit_len64", 96'(frm_len), 96'd64);
        chk("lit_cnt1", 96'(frm_count), 96'd1);
        chk("lit_ek0", 96'(frm_err_keep), 96'd0);

        // partial last beat
        push_frame(8, -1, 8'h00, 8'h1F);
        drain(100, 100);
        chk("lit_len61", 96'(frm_len), 96'd61);
        chk("lit_ek_61", 96'(frm_err_keep), 96'd0);

        // continuous stream with a 3-cycle stall
        push_frame(8, -1, 8'h00, 8'hFF);
        push_frame(8, -1, 8'h00, 8'hFF);
        step(100, 100);
        step(100, 100);
        step(100, 0);
        step(100, 0);
        step(100, 0);
        #1 chk("lit_stall_tready", 96'(s_tready), 96'd0);
        drain(100, 100);
        chk("lit_cnt4", 96'(frm_count), 96'd4);

        // keep violation mid-frame, then a clean frame
        push_frame(8, 2, 8'h7F, 8'h0F);
        drain(100, 100);
        chk("lit_len59", 96'(frm_len), 96'd59);
        chk("lit_ek1", 96'(frm_err_keep), 96'd1);
        push_frame(8, -1, 8'h00, 8'hFF);
        drain(100, 100);
        chk("lit_ek_clean", 96'(frm_err_keep), 96'd0);

        // oversize frame under random backpressure
        push_frame(192, -1, 8'h00, 8'h03);
        drain(80, 70);
        chk("lit_len1530", 96'(frm_len), 96'd1530);
        chk("lit_eo1", 96'(frm_err_oversize), 96'd1);
        chk("lit_cnt7", 96'(frm_count), 96'd7);

        // random frames
        for (int f = 0; f < 25; f++) begin
            n  = int'($urandom_range(1, 12));
            bi = ($urandom_range(9) == 0) ? int'($urandom_range(n - 1)) : -1;
            if ($urandom_range(1) == 0) lk = 8'((1 << $urandom_range(1, 8)) - 1);
            else                        lk = 8'($urandom_range(255));
            push_frame(n, bi, 8'($urandom_range(255)), lk);
        end
        drain(70, 60);

        // reset mid-frame, then a short frame
        push_frame(8, -1, 8'h00, 8'hFF);
        step(100, 100);
        step(100, 100);
        step(100, 100);
        do_reset();
        push_frame(2, -1, 8'h00, 8'hFF);
        drain(100, 100);
        chk("lit_len16", 96'(frm_len), 96'd16);
        chk("lit_cnt_after_rst", 96'(frm_count), 96'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_frame_rx.md
AXIS_FRAME_RX -- requirements
Module: axis_frame_rx

Interface
REQ-001 The block SHALL have parameter TDATA_WIDTH, default 64, AXI-Stream data width in bits, multiple of 8.
REQ-002 The block SHALL have parameter TID_WIDTH, default 1, tid width.
REQ-003 The block SHALL have parameter TDEST_WIDTH, default 1, tdest width.
REQ-004 The block SHALL have parameter TUSER_WIDTH, default 1, tuser width.
REQ-005 The block SHALL have parameter MAX_FRAME_BYTES, default 1522, oversize threshold in bytes.
REQ-006 The block SHALL use one clock, clk; reset is rst_n, asynchronous, active-low.
REQ-007 clk  in  1  sole clock; all logic on its rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 s_tvalid, s_tready, s_tlast  in, out, in  1 each  AXI-Stream slave handshake and end of frame.
REQ-010 s_tdata  in  TDATA_WIDTH  slave data.
REQ-011 s_tstrb, s_tkeep  in  TDATA_WIDTH/8 each  byte qualifiers.
REQ-012 s_tid, s_tdest, s_tuser  in  TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH  sideband.
REQ-013 m_tvalid, m_tready, m_tlast, m_tdata, m_tstrb, m_tkeep, m_tid, m_tdest, m_tuser  out (m_tready in)  same widths as the s_ ports  master-side forwarded stream.
REQ-014 frm_done  out  1  one-cycle pulse per completed frame.
REQ-015 frm_len  out  16  byte length of the last completed frame.
REQ-016 frm_err_keep  out  1  tkeep violation in the last completed frame.
REQ-017 frm_err_oversize  out  1  last completed frame exceeded MAX_FRAME_BYTES.
REQ-018 frm_count  out  32  count of completed frames.

Function
REQ-019 Beat acceptance SHALL occur on a clk edge with s_tvalid=1 and s_tready=1; master transfer with m_tvalid=1 and m_tready=1.
REQ-020 Datapath SHALL be a two-entry skid buffer (output register plus skid register) carrying all s_ fields unmodified.
REQ-021 s_tready SHALL be a registered signal equal to NOT skid_valid.
REQ-022 An accepted beat SHALL enter the output register if it is empty or draining this cycle, otherwise the skid register.
REQ-023 On a master transfer with skid_valid=1, the skid entry SHALL move to the output register in the same edge.
REQ-024 Forward latency SHALL be 1 cycle; with m_tready held 1, throughput SHALL be one beat per cycle.
REQ-025 Beats SHALL never be dropped, duplicated or reordered; m_tvalid SHALL not depend combinationally on m_tready.
REQ-026 Frame tracking FSM SHALL have states IDLE and IN_FRAME, evaluated on input acceptance only.
REQ-027 IDLE -> IN_FRAME on accepted beat with s_tlast=0; IN_FRAME -> IDLE on accepted beat with s_tlast=1; a single-beat frame in IDLE stays IDLE.
REQ-028 Byte count per beat SHALL be popcount(s_tkeep); frame length SHALL be the 16-bit sum over the frame, saturating at 65535.
REQ-029 tkeep rule: non-last beat SHALL be all ones; last beat SHALL be nonzero and contiguous from bit 0 (2^k-1); any violation sets the frame's keep error.
REQ-030 Oversize SHALL be set when the running length exceeds MAX_FRAME_BYTES; the frame is still forwarded unmodified.
REQ-031 On the edge after the last beat is accepted, frm_done SHALL be 1 for one cycle and frm_len, frm_err_keep, frm_err_oversize SHALL update and hold until the next frame completes.
REQ-032 frm_count SHALL increment with each frm_done and wrap from 2^32-1 to 0.
REQ-033 Frame statistics SHALL be independent of m_tready backpressure.
REQ-034 Accumulators SHALL clear at frame completion so a back-to-back frame starting on the next cycle is counted from zero.

Reset
REQ-035 On rst_n=0, s_tready, m_tvalid, skid_valid, frm_done, frm_err_keep, frm_err_oversize SHALL be 0; frm_len and frm_count 0; FSM IDLE; m_ data fields 0.
REQ-036 s_tready SHALL rise on the first clk edge after rst_n deasserts.
REQ-037 Reset mid-frame SHALL discard buffered beats and partial statistics with no frm_done pulse.

Verification
REQ-038 8 beats tkeep=0xFF, last on beat 8, m_tready=1 -> m_ beats 1 cycle later, identical; frm_done one cycle after beat 8; frm_len=64; errors 0; frm_count=1.
REQ-039 8 beats, last tkeep=0x1F -> frm_len=61, frm_err_keep=0.
REQ-040 Continuous stream, m_tready low 3 cycles -> s_tready low after 2 buffered beats; output sequence equals input exactly.
REQ-041 Beat 3 of 8 tkeep=0x7F, last 0x0F -> frm_err_keep=1, frm_len=59; next clean frame -> frm_err_keep=0.
REQ-042 1530-byte frame (191 beats 0xFF, last 0x03) -> frm_err_oversize=1, frm_len=1530.
REQ-043 rst_n pulsed low after 3 of 8 beats -> all outputs reset, no frm_done; then a 2-beat 0xFF frame -> frm_len=16, frm_count=1.
